// File: rtl/audio_sample_sequencer.sv
`default_nettype none
// ============================================================================
// audio_sample_sequencer
//   Pops stereo ADC samples and pushes them to the DAC, either directly or
//   after a mono running-mean filter.
//   Rev 1.0
// ============================================================================
module audio_sample_sequencer #(
    parameter int FILT_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             read_ready,
    input  logic [23:0]      readdata_left,
    input  logic [23:0]      readdata_right,
    output logic             read,
    input  logic             write_ready,
    output logic [23:0]      writedata_left,
    output logic [23:0]      writedata_right,
    output logic             write,
    output logic [23:0]      filt_in,
    output logic             filt_valid,
    input  logic [23:0]      filt_out,
    input  logic             bypass,
    output logic             busy,
    output logic [CNT_W-1:0] sample_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MIX  = 2'd1,
        S_WAIT = 2'd2,
        S_PUSH = 2'd3
    } state_t;

    localparam logic [3:0] C_WAIT_LAST = 4'(FILT_LAT - 1);

    state_t           state_q, state_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic             fv_q, fv_d;
    logic             busy_q, busy_d;
    logic [23:0]      fin_q, fin_d;
    logic [23:0]      wl_q, wl_d;
    logic [23:0]      wr_q, wr_d;
    logic [23:0]      l_q, l_d;
    logic [23:0]      r_q, r_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [24:0]      w_sum;

    // 25-bit sum keeps the carry; dropping bit 0 is a floor divide by two.
    assign w_sum = {l_q[23], l_q} + {r_q[23], r_q};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= '0;
            wl_q    <= '0;
            wr_q    <= '0;
            l_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            fv_q    <= fv_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            wl_q    <= wl_d;
            wr_q    <= wr_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        fv_d    = 1'b0;
        fin_d   = fin_q;
        wl_d    = wl_q;
        wr_d    = wr_q;
        l_d     = l_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (read_ready) begin
                    l_d    = readdata_left;
                    r_d    = readdata_right;
                    read_d = 1'b1;
                    if (bypass) begin
                        wl_d    = readdata_left;
                        wr_d    = readdata_right;
                        state_d = S_PUSH;
                    end else begin
                        state_d = S_MIX;
                    end
                end
            end
            S_MIX: begin
                fin_d   = w_sum[24:1];
                fv_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == C_WAIT_LAST) begin
                    wl_d    = filt_out;
                    wr_d    = filt_out;
                    state_d = S_PUSH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_PUSH: begin
                if (write_ready) begin
                    write_d = 1'b1;
                    count_d = count_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign read            = read_q;
    assign write           = write_q;
    assign filt_valid      = fv_q;
    assign filt_in         = fin_q;
    assign writedata_left  = wl_q;
    assign writedata_right = wr_q;
    assign busy            = busy_q;
    assign sample_count    = count_q;

endmodule
`default_nettype wire
